// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush controller: merges jump, EX, interrupt, bus and load-use
// requests into one hold level, and keeps stall statistics and a bus-hold watchdog.
module pipe_hold_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned BUS_TIMEOUT  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_ex_i,
    input  logic        hold_clint_i,
    input  logic        hold_rib_i,
    input  logic        load_use_i,
    input  logic        stat_clr_i,
    output logic [2:0]  hold_flag_o,
    output logic        jump_flag_o,
    output logic [31:0] jump_addr_o,
    output logic        flushing_o,
    output logic [31:0] stall_cnt_o,
    output logic        bus_timeout_o
);

    localparam logic [2:0]  HOLD_NONE  = 3'd0;
    localparam logic [2:0]  HOLD_PC    = 3'd1;
    localparam logic [2:0]  HOLD_IF    = 3'd2;
    localparam logic [2:0]  HOLD_ID    = 3'd3;
    localparam logic [2:0]  FLUSH_LOAD = 3'(FLUSH_CYCLES);
    localparam logic [15:0] BUS_MAX    = 16'(BUS_TIMEOUT);
    localparam logic [31:0] STALL_MAX  = 32'hFFFF_FFFF;

    logic [2:0]  flush_cnt_r;
    logic        lu_done_r;
    logic [15:0] bus_cnt_r;
    logic [31:0] stall_cnt_r;
    logic        bus_timeout_r;

    logic [2:0]  hold_s;
    logic        upper_win_s;
    logic        lu_win_s;
    logic        bus_hit_s;

    // Priority arbitration of all hold sources into a single level
    always_comb begin
        hold_s      = HOLD_NONE;
        upper_win_s = 1'b0;
        lu_win_s    = 1'b0;
        if (jump_flag_i || (flush_cnt_r != 3'd0) || hold_ex_i || hold_clint_i) begin
            hold_s      = HOLD_ID;
            upper_win_s = 1'b1;
        end else if (load_use_i && !lu_done_r) begin
            hold_s   = HOLD_IF;
            lu_win_s = 1'b1;
        end else if (hold_rib_i) begin
            hold_s = HOLD_PC;
        end else begin
            hold_s = HOLD_NONE;
        end
    end

    // The watchdog fires only on the transition into the timeout count
    assign bus_hit_s = hold_rib_i && (bus_cnt_r == (BUS_MAX - 16'd1));

    // Reset forces the combinational outputs low even while inputs are active
    assign hold_flag_o   = rst ? HOLD_NONE : hold_s;
    assign jump_flag_o   = rst ? 1'b0 : jump_flag_i;
    assign jump_addr_o   = (rst || !jump_flag_i) ? 32'd0 : jump_addr_i;
    assign flushing_o    = (flush_cnt_r != 3'd0);
    assign stall_cnt_o   = stall_cnt_r;
    assign bus_timeout_o = bus_timeout_r;

    // Post-jump flush stretch and load-use one-shot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt_r <= 3'd0;
            lu_done_r   <= 1'b0;
        end else begin
            if (jump_flag_i) begin
                flush_cnt_r <= FLUSH_LOAD;
            end else if (flush_cnt_r != 3'd0) begin
                flush_cnt_r <= flush_cnt_r - 3'd1;
            end else begin
                flush_cnt_r <= 3'd0;
            end
            if (!load_use_i || upper_win_s) begin
                lu_done_r <= 1'b0;
            end else if (lu_win_s) begin
                lu_done_r <= 1'b1;
            end else begin
                lu_done_r <= lu_done_r;
            end
        end
    end

    // Bus-hold run length, stall statistics and sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_cnt_r     <= 16'd0;
            stall_cnt_r   <= 32'd0;
            bus_timeout_r <= 1'b0;
        end else begin
            if (!hold_rib_i) begin
                bus_cnt_r <= 16'd0;
            end else if (bus_cnt_r != BUS_MAX) begin
                bus_cnt_r <= bus_cnt_r + 16'd1;
            end else begin
                bus_cnt_r <= bus_cnt_r;
            end
            if (stat_clr_i) begin
                stall_cnt_r   <= 32'd0;
                bus_timeout_r <= 1'b0;
            end else begin
                if ((hold_s != HOLD_NONE) && (stall_cnt_r != STALL_MAX)) begin
                    stall_cnt_r <= stall_cnt_r + 32'd1;
                end else begin
                    stall_cnt_r <= stall_cnt_r;
                end
                if (bus_hit_s) begin
                    bus_timeout_r <= 1'b1;
                end else begin
                    bus_timeout_r <= bus_timeout_r;
                end
            end
        end
    end

endmodule
